// File: rtl/velocity_arbiter.sv
// velocity_arbiter: arbitrates hit/border/line/friction updates onto a registered ball velocity
// with one-deep pending slots, fixed priority and a REST/MOVING state machine.
module velocity_arbiter #(
    parameter int MAX_SPEED     = 1000,
    parameter int FRICTION_STEP = 1,
    parameter int FRICTION_DIV  = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               hitReq,
    input  logic signed [10:0] hitVX,
    input  logic signed [10:0] hitVY,
    input  logic               lineReq,
    input  logic signed [10:0] lineVX,
    input  logic signed [10:0] lineVY,
    input  logic               borderReq,
    input  logic               borderFlipX,
    input  logic               borderFlipY,
    input  logic               frameTick,
    output logic signed [10:0] outVelocityX,
    output logic signed [10:0] outVelocityY,
    output logic               writeEnable,
    output logic               hitAck,
    output logic               lineAck,
    output logic               borderAck,
    output logic               lineReject,
    output logic               moving,
    output logic               stopped,
    output logic               overflow
);
    localparam logic signed [11:0] MAXV = 12'(MAX_SPEED);
    localparam logic signed [11:0] STEP = 12'(FRICTION_STEP);
    localparam logic [7:0]         LAST = 8'(FRICTION_DIV - 1);

    typedef enum logic {REST, MOVING} state_t;
    state_t state;

    logic               hit_v, line_v, border_v, fric_v, border_fx, border_fy;
    logic signed [10:0] hit_x, hit_y, line_x, line_y, nx, ny;
    logic [7:0]         frame_cnt;
    logic               sh, sb, sl, sf, wr, fric_req;

    function automatic logic signed [10:0] clamp(input logic signed [10:0] v);
        logic signed [11:0] w;
        w = {v[10], v};
        return w > MAXV ? 11'(MAXV) : w < -MAXV ? 11'(-MAXV) : v;
    endfunction

    // -1024 has no positive counterpart in 11 bits, so it saturates to +1023
    function automatic logic signed [10:0] neg(input logic signed [10:0] v);
        return v == {1'b1, 10'b0} ? 11'sd1023 : -v;
    endfunction

    function automatic logic signed [10:0] fric(input logic signed [10:0] v);
        logic signed [11:0] w;
        w = {v[10], v};
        return w > STEP ? 11'(w - STEP) : w < -STEP ? 11'(w + STEP) : 11'sd0;
    endfunction

    assign moving   = state == MOVING;
    assign fric_req = frameTick && frame_cnt == LAST;
    assign sh = hit_v;
    assign sb = border_v & ~hit_v;
    assign sl = line_v & ~hit_v & ~border_v;
    assign sf = fric_v & ~hit_v & ~border_v & ~line_v;
    assign wr = sh | sb | (sl & ~moving) | (sf & moving);
    assign nx = sh ? clamp(hit_x) : sb ? clamp(border_fx ? neg(outVelocityX) : outVelocityX) :
                sl ? clamp(line_x) : fric(outVelocityX);
    assign ny = sh ? clamp(hit_y) : sb ? clamp(border_fy ? neg(outVelocityY) : outVelocityY) :
                sl ? clamp(line_y) : fric(outVelocityY);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= REST;
            outVelocityX <= '0;
            outVelocityY <= '0;
            {hit_v, line_v, border_v, fric_v} <= '0;
            {hit_x, hit_y, line_x, line_y}    <= '0;
            {border_fx, border_fy}            <= '0;
            frame_cnt    <= '0;
            {writeEnable, hitAck, lineAck, borderAck, lineReject, stopped, overflow} <= '0;
        end else begin
            // a request always (re)loads its slot; service only clears it when no new request lands
            hit_v    <= hitReq | (hit_v & ~sh);
            border_v <= borderReq | (border_v & ~sb);
            line_v   <= lineReq | (line_v & ~sl);
            fric_v   <= fric_req | (fric_v & ~sf);
            if (hitReq) {hit_x, hit_y} <= {hitVX, hitVY};
            if (lineReq) {line_x, line_y} <= {lineVX, lineVY};
            if (borderReq) {border_fx, border_fy} <= {borderFlipX, borderFlipY};
            if (frameTick) frame_cnt <= fric_req ? 8'd0 : frame_cnt + 8'd1;
            overflow <= overflow | (hitReq & hit_v & ~sh) | (borderReq & border_v & ~sb) |
                        (lineReq & line_v & ~sl) | (fric_req & fric_v & ~sf);
            writeEnable <= wr;
            hitAck      <= sh;
            borderAck   <= sb;
            lineAck     <= sl & ~moving;
            lineReject  <= sl & moving;
            stopped     <= wr & moving & nx == 0 & ny == 0;
            if (wr) begin
                outVelocityX <= nx;
                outVelocityY <= ny;
                state        <= (nx != 0 || ny != 0) ? MOVING : REST;
            end
        end
    end
endmodule

// File: tb/tb_velocity_arbiter.sv
// tb_velocity_arbiter: directed and randomized checks of velocity_arbiter against a
// behavioural model of pending slots, priority service and the REST/MOVING rules.
module tb_velocity_arbiter;
    localparam int MAXS = 1000, STEP = 1, DIV = 4;

    logic clk = 0, reset = 1;
    logic hitReq = 0, lineReq = 0, borderReq = 0, borderFlipX = 0, borderFlipY = 0, frameTick = 0;
    logic signed [10:0] hitVX = 0, hitVY = 0, lineVX = 0, lineVY = 0;
    logic signed [10:0] outVelocityX, outVelocityY;
    logic writeEnable, hitAck, lineAck, borderAck, lineReject, moving, stopped, overflow;
    int vecs = 0, errs = 0;

    always #5 clk = ~clk;

    velocity_arbiter dut (
        .clk(clk), .reset(reset),
        .hitReq(hitReq), .hitVX(hitVX), .hitVY(hitVY),
        .lineReq(lineReq), .lineVX(lineVX), .lineVY(lineVY),
        .borderReq(borderReq), .borderFlipX(borderFlipX), .borderFlipY(borderFlipY),
        .frameTick(frameTick),
        .outVelocityX(outVelocityX), .outVelocityY(outVelocityY),
        .writeEnable(writeEnable), .hitAck(hitAck), .lineAck(lineAck), .borderAck(borderAck),
        .lineReject(lineReject), .moving(moving), .stopped(stopped), .overflow(overflow)
    );

    // model state: sources indexed in priority order hit, border, line, friction
    int mvx, mvy, mticks;
    bit mmove, m_we, m_hack, m_lack, m_back, m_rej, m_stop, m_ov;
    bit pend[4];
    int pa[4], pb[4];

    function automatic int clampi(int v);
        return v > MAXS ? MAXS : (v < -MAXS ? -MAXS : v);
    endfunction

    function automatic int negi(int v);
        return -v > 1023 ? 1023 : -v;
    endfunction

    function automatic int towards0(int v);
        if (v > STEP) return v - STEP;
        if (v < -STEP) return v + STEP;
        return 0;
    endfunction

    function automatic void check(string name, int act, int exp);
        vecs++;
        if (act != exp) begin
            errs++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    task automatic model_reset();
        mvx = 0; mvy = 0; mticks = 0; mmove = 0;
        {m_we, m_hack, m_lack, m_back, m_rej, m_stop, m_ov} = '0;
        for (int i = 0; i < 4; i++) begin pend[i] = 0; pa[i] = 0; pb[i] = 0; end
    endtask

    task automatic model_step();
        int s, nx, ny;
        bit wr;
        bit req[4];
        int ra[4], rb[4];
        s = 4; nx = mvx; ny = mvy; wr = 0;
        for (int i = 3; i >= 0; i--) if (pend[i]) s = i;
        {m_we, m_hack, m_lack, m_back, m_rej, m_stop} = '0;
        case (s)
            0: begin nx = clampi(pa[0]); ny = clampi(pb[0]); wr = 1; m_hack = 1; end
            1: begin
                nx = clampi(pa[1] != 0 ? negi(mvx) : mvx);
                ny = clampi(pb[1] != 0 ? negi(mvy) : mvy);
                wr = 1; m_back = 1;
            end
            2: if (mmove) m_rej = 1;
               else begin nx = clampi(pa[2]); ny = clampi(pb[2]); wr = 1; m_lack = 1; end
            3: if (mmove) begin nx = towards0(mvx); ny = towards0(mvy); wr = 1; end
            default: ;
        endcase
        if (wr) begin
            m_we = 1;
            m_stop = mmove && nx == 0 && ny == 0;
            mvx = nx; mvy = ny;
            mmove = nx != 0 || ny != 0;
        end
        req[0] = hitReq;    ra[0] = hitVX;       rb[0] = hitVY;
        req[1] = borderReq; ra[1] = borderFlipX; rb[1] = borderFlipY;
        req[2] = lineReq;   ra[2] = lineVX;      rb[2] = lineVY;
        req[3] = 0;         ra[3] = 0;           rb[3] = 0;
        if (frameTick) begin
            mticks++;
            if (mticks == DIV) begin mticks = 0; req[3] = 1; end
        end
        for (int i = 0; i < 4; i++) begin
            if (req[i]) begin
                if (pend[i] && s != i) m_ov = 1;
                pend[i] = 1; pa[i] = ra[i]; pb[i] = rb[i];
            end else if (s == i) pend[i] = 0;
        end
    endtask

    always @(posedge clk) if (!reset) model_step();

    always @(negedge clk) begin
        check("outVelocityX", outVelocityX, mvx);
        check("outVelocityY", outVelocityY, mvy);
        check("writeEnable", int'(writeEnable), int'(m_we));
        check("hitAck", int'(hitAck), int'(m_hack));
        check("lineAck", int'(lineAck), int'(m_lack));
        check("borderAck", int'(borderAck), int'(m_back));
        check("lineReject", int'(lineReject), int'(m_rej));
        check("moving", int'(moving), int'(mmove));
        check("stopped", int'(stopped), int'(m_stop));
        check("overflow", int'(overflow), int'(m_ov));
    end

    task automatic clr();
        hitReq = 0; lineReq = 0; borderReq = 0; frameTick = 0;
    endtask

    int wx[8], wy[8];
    int wcnt, stops, seen;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        reset = 0;
        check("rst_outX", outVelocityX, 0);
        check("rst_outY", outVelocityY, 0);
        check("rst_moving", int'(moving), 0);
        check("rst_overflow", int'(overflow), 0);
        // line strike from rest
        lineReq = 1; lineVX = 300; lineVY = -200;
        @(negedge clk); clr();
        @(negedge clk);
        check("line_we", int'(writeEnable), 1);
        check("line_ack", int'(lineAck), 1);
        check("line_x", outVelocityX, 300);
        check("line_y", outVelocityY, -200);
        check("line_moving", int'(moving), 1);
        // hit beats line; line then rejected while moving
        hitReq = 1; hitVX = 50; hitVY = 50; lineReq = 1; lineVX = 10; lineVY = 10;
        @(negedge clk); clr();
        @(negedge clk);
        check("hl_hitack", int'(hitAck), 1);
        check("hl_x", outVelocityX, 50);
        @(negedge clk);
        check("hl_reject", int'(lineReject), 1);
        check("hl_lineack", int'(lineAck), 0);
        check("hl_we", int'(writeEnable), 0);
        check("hl_y", outVelocityY, 50);
        // hit clamp, then border flip of the clamped negative component
        hitReq = 1; hitVX = -1024; hitVY = 5;
        @(negedge clk); clr();
        @(negedge clk);
        check("clamp_x", outVelocityX, -1000);
        check("clamp_y", outVelocityY, 5);
        borderReq = 1; borderFlipX = 1; borderFlipY = 0;
        @(negedge clk); clr();
        @(negedge clk);
        check("flip_ack", int'(borderAck), 1);
        check("flip_x", outVelocityX, 1000);
        check("flip_y", outVelocityY, 5);
        // back-to-back hits with border pending; border overwritten while unserved
        hitReq = 1; hitVX = 11; hitVY = 12; borderReq = 1; borderFlipX = 0; borderFlipY = 1;
        @(negedge clk);
        hitVX = 13; hitVY = 14; borderFlipX = 1; borderFlipY = 0;
        @(negedge clk); clr();
        check("ovf_x1", outVelocityX, 11);
        check("ovf_flag", int'(overflow), 1);
        @(negedge clk);
        check("ovf_x2", outVelocityX, 13);
        check("ovf_y2", outVelocityY, 14);
        @(negedge clk);
        check("ovf_back", int'(borderAck), 1);
        check("ovf_bx", outVelocityX, -13);
        check("ovf_by", outVelocityY, 14);
        // friction decay from (3,-2) over 12 frame ticks
        hitReq = 1; hitVX = 3; hitVY = -2;
        @(negedge clk); clr();
        @(negedge clk);
        wcnt = 0; stops = 0;
        for (int t = 0; t < 15; t++) begin
            frameTick = t < 12;
            for (int c = 0; c < 3; c++) begin
                @(negedge clk); frameTick = 0;
                if (writeEnable && wcnt < 8) begin
                    wx[wcnt] = outVelocityX; wy[wcnt] = outVelocityY; wcnt++;
                end
                if (stopped) stops++;
            end
        end
        check("fric_writes", wcnt, 3);
        check("fric_w0x", wx[0], 2);
        check("fric_w0y", wy[0], -1);
        check("fric_w1x", wx[1], 1);
        check("fric_w1y", wy[1], 0);
        check("fric_w2x", wx[2], 0);
        check("fric_w2y", wy[2], 0);
        check("fric_stops", stops, 1);
        check("fric_moving", int'(moving), 0);
        // reset while a hit is pending service
        hitReq = 1; hitVX = 40; hitVY = 40;
        @(negedge clk); clr();
        @(negedge clk);
        hitReq = 1; hitVX = 20; hitVY = 20;
        @(negedge clk); clr();
        #2 reset = 1; model_reset();
        #1;
        check("mrst_x", outVelocityX, 0);
        check("mrst_moving", int'(moving), 0);
        check("mrst_we", int'(writeEnable), 0);
        @(negedge clk); reset = 0;
        seen = 0;
        repeat (4) begin @(negedge clk); seen += int'(writeEnable | hitAck); end
        check("mrst_nowrite", seen, 0);
        // randomized traffic
        for (int n = 0; n < 4000; n++) begin
            hitReq = $urandom_range(0, 11) == 0;
            lineReq = $urandom_range(0, 7) == 0;
            borderReq = $urandom_range(0, 9) == 0;
            frameTick = $urandom_range(0, 2) == 0;
            borderFlipX = 1'($urandom); borderFlipY = 1'($urandom);
            hitVX = 11'($urandom); hitVY = 11'($urandom);
            lineVX = 11'($urandom); lineVY = 11'($urandom);
            if ($urandom_range(0, 3) == 0) begin hitVX = 11'($urandom_range(0, 6)) - 11'sd3; hitVY = 0; end
            @(negedge clk);
        end
        clr();
        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
